wspd_window_stats: RTL and testbench

- Consumes the calibrated wind-speed sample stream (16-bit value plus single-cycle valid pulse) from the wind-speed calibration stage.
- Produces a sliding-window moving average over the last 2^LOG2N samples.
- Produces a peak "gust" value per non-overlapping block of 2^LOG2N samples.
- Sits directly downstream of calibration and feeds the reporting/output interface.

---
 rtl/wspd_window_stats.sv | 130 +++++++++++++
 tb/tb_wspd_window_stats.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/wspd_window_stats.sv
// Sliding-window moving average and per-block gust (peak) tracker for the
// calibrated wind-speed stream; window and block depth are both 2^LOG2N.
module wspd_window_stats #(
  parameter int LOG2N = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        in_valid,
  input  logic [15:0] in,
  output logic        avg_valid,
  output logic [15:0] avg,
  output logic        gust_valid,
  output logic [15:0] gust,
  output logic        window_full
);

  localparam int DEPTH = 1 << LOG2N;
  localparam int SW    = 16 + LOG2N;
  localparam logic [LOG2N:0]   DEPTH_C = (LOG2N + 1)'(DEPTH);
  localparam logic [LOG2N-1:0] BLAST_C = LOG2N'(DEPTH - 1);

  function automatic logic [15:0] max16(input logic [15:0] a, input logic [15:0] b);
    if (a > b) return a;
    else       return b;
  endfunction

  logic [15:0]      mem_q [DEPTH];
  logic [SW-1:0]    sum_q, sum_d;
  logic [LOG2N:0]   count_q, count_d;
  logic [LOG2N-1:0] wptr_q, wptr_d;
  logic [LOG2N-1:0] bcnt_q, bcnt_d;
  logic [15:0]      bmax_q, bmax_d;
  logic             avg_valid_q, avg_valid_d;
  logic [15:0]      avg_q, avg_d;
  logic             gust_valid_q, gust_valid_d;
  logic [15:0]      gust_q, gust_d;
  logic             window_full_q, window_full_d;

  logic             full_s;
  logic             mem_we_s;
  logic [15:0]      old_s;
  logic [15:0]      peak_s;
  logic [SW-1:0]    sum_next_s;

  // Next-state logic: clear dominates a coincident sample; otherwise one accept per cycle.
  always_comb begin
    full_s        = (count_q == DEPTH_C);
    old_s         = full_s ? mem_q[wptr_q] : 16'd0;
    sum_next_s    = sum_q + SW'(in) - SW'(old_s);
    peak_s        = max16(bmax_q, in);
    mem_we_s      = 1'b0;
    sum_d         = sum_q;
    count_d       = count_q;
    wptr_d        = wptr_q;
    bcnt_d        = bcnt_q;
    bmax_d        = bmax_q;
    avg_valid_d   = 1'b0;
    avg_d         = avg_q;
    gust_valid_d  = 1'b0;
    gust_d        = gust_q;
    window_full_d = window_full_q;
    if (clear) begin
      sum_d         = '0;
      count_d       = '0;
      wptr_d        = '0;
      bcnt_d        = '0;
      bmax_d        = 16'd0;
      window_full_d = 1'b0;
    end else if (in_valid) begin
      mem_we_s      = 1'b1;
      sum_d         = sum_next_s;
      wptr_d        = wptr_q + LOG2N'(1);
      count_d       = full_s ? count_q : count_q + (LOG2N + 1)'(1);
      window_full_d = (count_d == DEPTH_C);
      avg_valid_d   = 1'b1;
      // sum carries LOG2N extra bits, so the shifted result always fits 16 bits
      avg_d         = sum_next_s[LOG2N +: 16];
      bmax_d        = (bcnt_q == '0) ? in : peak_s;
      bcnt_d        = bcnt_q + LOG2N'(1);
      if (bcnt_q == BLAST_C) begin
        gust_valid_d = 1'b1;
        gust_d       = peak_s;
      end else begin
        gust_valid_d = 1'b0;
      end
    end else begin
      mem_we_s = 1'b0;
    end
  end

  // Sample ring buffer; contents deliberately survive reset and clear.
  always_ff @(posedge clk) begin
    if (mem_we_s) mem_q[wptr_q] <= in;
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sum_q         <= '0;
      count_q       <= '0;
      wptr_q        <= '0;
      bcnt_q        <= '0;
      bmax_q        <= 16'd0;
      avg_valid_q   <= 1'b0;
      avg_q         <= 16'd0;
      gust_valid_q  <= 1'b0;
      gust_q        <= 16'd0;
      window_full_q <= 1'b0;
    end else begin
      sum_q         <= sum_d;
      count_q       <= count_d;
      wptr_q        <= wptr_d;
      bcnt_q        <= bcnt_d;
      bmax_q        <= bmax_d;
      avg_valid_q   <= avg_valid_d;
      avg_q         <= avg_d;
      gust_valid_q  <= gust_valid_d;
      gust_q        <= gust_d;
      window_full_q <= window_full_d;
    end
  end

  assign avg_valid   = avg_valid_q;
  assign avg         = avg_q;
  assign gust_valid  = gust_valid_q;
  assign gust        = gust_q;
  assign window_full = window_full_q;

endmodule

// File: tb/tb_wspd_window_stats.sv
// Directed table-driven bench for wspd_window_stats with LOG2N=2 (DEPTH=4),
// plus hand sequences for gapped full-scale input and mid-window async reset.
module tb_wspd_window_stats;

  logic        clk;
  logic        reset;
  logic        clear;
  logic        in_valid;
  logic [15:0] in_s;
  logic        avg_valid;
  logic [15:0] avg;
  logic        gust_valid;
  logic [15:0] gust;
  logic        window_full;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic        v;
    logic        c;
    logic [15:0] d;
    logic        e_av;
    logic [15:0] e_avg;
    logic        e_gv;
    logic [15:0] e_gust;
    logic        e_wf;
  } vec_t;

  vec_t tbl[$];

  wspd_window_stats #(.LOG2N(2)) dut (
    .clk        (clk),
    .reset      (reset),
    .clear      (clear),
    .in_valid   (in_valid),
    .in         (in_s),
    .avg_valid  (avg_valid),
    .avg        (avg),
    .gust_valid (gust_valid),
    .gust       (gust),
    .window_full(window_full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(input logic v, input logic c, input logic [15:0] d,
                     input logic av, input logic [15:0] a, input logic gv,
                     input logic [15:0] g, input logic wf);
    vec_t r;
    r.v = v; r.c = c; r.d = d; r.e_av = av; r.e_avg = a;
    r.e_gv = gv; r.e_gust = g; r.e_wf = wf;
    tbl.push_back(r);
  endtask

  task automatic step(input logic v, input logic c, input logic [15:0] d);
    @(negedge clk);
    in_valid = v;
    clear    = c;
    in_s     = d;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int pulses;
    int acc;
    logic [15:0] exp_avg;

    reset = 1'b0; clear = 1'b0; in_valid = 1'b0; in_s = 16'h0000;

    //        v     c     in        av    avg       gv    gust      wf
    add(1'b1, 1'b0, 16'h6EEE, 1'b1, 16'h1BBB, 1'b0, 16'h0000, 1'b0);
    add(1'b0, 1'b1, 16'h0000, 1'b0, 16'h1BBB, 1'b0, 16'h0000, 1'b0);
    add(1'b1, 1'b0, 16'h1000, 1'b1, 16'h0400, 1'b0, 16'h0000, 1'b0);
    add(1'b1, 1'b0, 16'h1000, 1'b1, 16'h0800, 1'b0, 16'h0000, 1'b0);
    add(1'b1, 1'b0, 16'h1000, 1'b1, 16'h0C00, 1'b0, 16'h0000, 1'b0);
    add(1'b1, 1'b0, 16'h1000, 1'b1, 16'h1000, 1'b1, 16'h1000, 1'b1);
    add(1'b1, 1'b0, 16'h0000, 1'b1, 16'h0C00, 1'b0, 16'h1000, 1'b1);
    add(1'b0, 1'b1, 16'h0000, 1'b0, 16'h0C00, 1'b0, 16'h1000, 1'b0);
    add(1'b1, 1'b0, 16'h0100, 1'b1, 16'h0040, 1'b0, 16'h1000, 1'b0);
    add(1'b1, 1'b0, 16'h0500, 1'b1, 16'h0180, 1'b0, 16'h1000, 1'b0);
    add(1'b1, 1'b0, 16'h0300, 1'b1, 16'h0240, 1'b0, 16'h1000, 1'b0);
    add(1'b1, 1'b0, 16'h0200, 1'b1, 16'h02C0, 1'b1, 16'h0500, 1'b1);
    add(1'b1, 1'b0, 16'h0010, 1'b1, 16'h0284, 1'b0, 16'h0500, 1'b1);
    add(1'b1, 1'b0, 16'h0010, 1'b1, 16'h0148, 1'b0, 16'h0500, 1'b1);
    add(1'b1, 1'b0, 16'h0010, 1'b1, 16'h008C, 1'b0, 16'h0500, 1'b1);
    add(1'b1, 1'b0, 16'h0010, 1'b1, 16'h0010, 1'b1, 16'h0010, 1'b1);
    add(1'b0, 1'b0, 16'h0000, 1'b0, 16'h0010, 1'b0, 16'h0010, 1'b1);
    add(1'b0, 1'b1, 16'h0000, 1'b0, 16'h0010, 1'b0, 16'h0010, 1'b0);
    add(1'b1, 1'b0, 16'h2000, 1'b1, 16'h0800, 1'b0, 16'h0010, 1'b0);
    add(1'b1, 1'b0, 16'h2000, 1'b1, 16'h1000, 1'b0, 16'h0010, 1'b0);
    add(1'b1, 1'b0, 16'h2000, 1'b1, 16'h1800, 1'b0, 16'h0010, 1'b0);
    add(1'b1, 1'b0, 16'h2000, 1'b1, 16'h2000, 1'b1, 16'h2000, 1'b1);
    add(1'b1, 1'b1, 16'h4000, 1'b0, 16'h2000, 1'b0, 16'h2000, 1'b0);
    add(1'b1, 1'b0, 16'h4000, 1'b1, 16'h1000, 1'b0, 16'h2000, 1'b0);

    // reset state
    #12;
    chk("rst_avg_valid", 16'(avg_valid), 16'h0000);
    chk("rst_avg", avg, 16'h0000);
    chk("rst_gust_valid", 16'(gust_valid), 16'h0000);
    chk("rst_gust", gust, 16'h0000);
    chk("rst_window_full", 16'(window_full), 16'h0000);
    @(negedge clk);
    reset = 1'b1;

    foreach (tbl[i]) begin
      step(tbl[i].v, tbl[i].c, tbl[i].d);
      chk($sformatf("v%0d_avg_valid", i), 16'(avg_valid), 16'(tbl[i].e_av));
      chk($sformatf("v%0d_avg", i), avg, tbl[i].e_avg);
      chk($sformatf("v%0d_gust_valid", i), 16'(gust_valid), 16'(tbl[i].e_gv));
      chk($sformatf("v%0d_gust", i), gust, tbl[i].e_gust);
      chk($sformatf("v%0d_window_full", i), 16'(window_full), 16'(tbl[i].e_wf));
    end

    // full-scale samples with random idle gaps
    step(1'b0, 1'b1, 16'h0000);
    pulses = 0;
    for (int k = 1; k <= 8; k++) begin
      int gap;
      gap = $urandom_range(3, 0);
      for (int g = 0; g < gap; g++) begin
        step(1'b0, 1'b0, 16'h0000);
        if (gust_valid) pulses++;
        chk($sformatf("fs%0d_gap_avg_valid", k), 16'(avg_valid), 16'h0000);
      end
      step(1'b1, 1'b0, 16'hFFFF);
      if (gust_valid) pulses++;
      acc = ((k < 4) ? k : 4) * 65535;
      exp_avg = 16'(acc >> 2);
      chk($sformatf("fs%0d_avg_valid", k), 16'(avg_valid), 16'h0001);
      chk($sformatf("fs%0d_avg", k), avg, exp_avg);
      chk($sformatf("fs%0d_gust_valid", k), 16'(gust_valid), 16'((k % 4) == 0));
      chk($sformatf("fs%0d_window_full", k), 16'(window_full), 16'(k >= 4));
      if ((k % 4) == 0) chk($sformatf("fs%0d_gust", k), gust, 16'hFFFF);
    end
    step(1'b0, 1'b0, 16'h0000);
    if (gust_valid) pulses++;
    chk("fs_gust_pulse_count", 16'(pulses), 16'd2);

    // asynchronous reset while the window is full
    chk("pre_areset_window_full", 16'(window_full), 16'h0001);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("areset_avg", avg, 16'h0000);
    chk("areset_gust", gust, 16'h0000);
    chk("areset_window_full", 16'(window_full), 16'h0000);
    chk("areset_avg_valid", 16'(avg_valid), 16'h0000);
    chk("areset_gust_valid", 16'(gust_valid), 16'h0000);
    @(negedge clk);
    reset = 1'b1;
    step(1'b1, 1'b0, 16'h0800);
    chk("post_reset_avg_valid", 16'(avg_valid), 16'h0001);
    chk("post_reset_avg", avg, 16'h0200);
    chk("post_reset_window_full", 16'(window_full), 16'h0000);
    chk("post_reset_gust_valid", 16'(gust_valid), 16'h0000);
    step(1'b0, 1'b0, 16'h0000);
    chk("post_reset_pulse_end", 16'(avg_valid), 16'h0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
